tm1638_refresh_ctrl: RTL and testbench

Serial-interface sequencer for the TM1638 display/LED driver. It takes eight segment bytes from the per-digit 7-segment decoders plus eight discrete LED bits. On each refresh request it emits the full TM1638 write sequence on STB/CLK/DIO: data-command, address+16 data bytes, display-control. It sits between the decoder bank and the board pins. The block is write-only; there is no key scan.

---
 rtl/tm1638_refresh_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_tm1638_refresh_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_refresh_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tm1638_refresh_ctrl
// Brief    : Refresh sequencer driving TM1638 STB/CLK/DIO (cmd, 17 data, ctrl)
// Revision : 1.0
// ============================================================================
module tm1638_refresh_ctrl #(
  parameter int         CLK_DIV    = 50,
  parameter logic [2:0] BRIGHTNESS = 3'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] seg_data,
  input  logic [7:0]  led,
  output logic        busy,
  output logic        done,
  output logic        tm_stb,
  output logic        tm_clk,
  output logic        tm_dio
);

  localparam int             DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  c_div_last = DW'(CLK_DIV - 1);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_cmd  = 3'd1;
  localparam logic [2:0] c_st_gap1 = 3'd2;
  localparam logic [2:0] c_st_data = 3'd3;
  localparam logic [2:0] c_st_gap2 = 3'd4;
  localparam logic [2:0] c_st_ctrl = 3'd5;
  localparam logic [2:0] c_st_gap3 = 3'd6;

  // Within a frame: setup / bit-low / bit-high / hold. Gaps reuse setup and lo as halves.
  localparam logic [1:0] c_ph_setup = 2'd0;
  localparam logic [1:0] c_ph_lo    = 2'd1;
  localparam logic [1:0] c_ph_hi    = 2'd2;
  localparam logic [1:0] c_ph_hold  = 2'd3;

  logic [2:0]    r_state, w_state_n;
  logic [1:0]    r_ph, w_ph_n;
  logic [DW-1:0] r_div, w_div_n;
  logic [2:0]    r_bit, w_bit_n;
  logic [4:0]    r_byte, w_byte_n;
  logic [63:0]   r_seg;
  logic [7:0]    r_led;
  logic          w_latch;
  logic          w_tick;
  logic [4:0]    w_last_byte;
  logic          r_stb, r_clk, r_dio, r_busy, r_done;
  logic          w_stb_n, w_clk_n, w_dio_n, w_busy_n, w_done_n;
  logic          w_in_frame_n;
  logic [7:0]    w_tx_byte;

  function automatic logic [7:0] frame_byte(input logic [2:0]  st,
                                            input logic [4:0]  idx,
                                            input logic [63:0] seg_v,
                                            input logic [7:0]  led_v);
    logic [2:0] li;
    logic [7:0] b;
    b  = 8'hFF;
    li = idx[3:1] - 3'd1;  // even index 2i+2 -> i; index 16 wraps to 7
    case (st)
      c_st_cmd:  b = 8'h40;
      c_st_ctrl: b = {5'b10001, BRIGHTNESS};
      c_st_data: begin
        if (idx == 5'd0)  b = 8'hC0;
        else if (idx[0]) b = seg_v[{idx[3:1], 3'b000} +: 8];
        else             b = {7'b0, led_v[li]};
      end
      default:   b = 8'hFF;
    endcase
    return b;
  endfunction

  assign w_tick      = (r_div == c_div_last);
  assign w_last_byte = (r_state == c_st_data) ? 5'd16 : 5'd0;

  always_ff @(posedge clk or posedge rst) begin : p_state
    if (rst) begin
      r_state <= c_st_idle;
      r_ph    <= c_ph_setup;
      r_div   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_seg   <= '0;
      r_led   <= '0;
      r_stb   <= 1'b1;
      r_clk   <= 1'b1;
      r_dio   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ph    <= w_ph_n;
      r_div   <= w_div_n;
      r_bit   <= w_bit_n;
      r_byte  <= w_byte_n;
      if (w_latch) begin
        r_seg <= seg_data;
        r_led <= led;
      end
      r_stb   <= w_stb_n;
      r_clk   <= w_clk_n;
      r_dio   <= w_dio_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  always_comb begin : p_next
    w_state_n = r_state;
    w_ph_n    = r_ph;
    w_div_n   = r_div;
    w_bit_n   = r_bit;
    w_byte_n  = r_byte;
    w_latch   = 1'b0;
    case (r_state)
      c_st_idle: begin
        w_div_n = '0;
        if (start) begin
          w_state_n = c_st_cmd;
          w_ph_n    = c_ph_setup;
          w_bit_n   = '0;
          w_byte_n  = '0;
          w_latch   = 1'b1;
        end
      end
      c_st_cmd, c_st_data, c_st_ctrl: begin
        w_div_n = w_tick ? '0 : r_div + 1'b1;
        if (w_tick) begin
          case (r_ph)
            c_ph_setup: w_ph_n = c_ph_lo;
            c_ph_lo:    w_ph_n = c_ph_hi;
            c_ph_hi: begin
              if (r_bit == 3'd7 && r_byte == w_last_byte) begin
                w_ph_n = c_ph_hold;
              end else begin
                w_ph_n  = c_ph_lo;
                w_bit_n = r_bit + 1'b1;
                if (r_bit == 3'd7) w_byte_n = r_byte + 1'b1;
              end
            end
            default: begin
              w_ph_n   = c_ph_setup;
              w_bit_n  = '0;
              w_byte_n = '0;
              case (r_state)
                c_st_cmd:  w_state_n = c_st_gap1;
                c_st_data: w_state_n = c_st_gap2;
                default:   w_state_n = c_st_gap3;
              endcase
            end
          endcase
        end
      end
      c_st_gap1, c_st_gap2, c_st_gap3: begin
        w_div_n = w_tick ? '0 : r_div + 1'b1;
        if (w_tick) begin
          if (r_ph == c_ph_setup) begin
            w_ph_n = c_ph_lo;
          end else begin
            w_ph_n = c_ph_setup;
            case (r_state)
              c_st_gap1: w_state_n = c_st_data;
              c_st_gap2: w_state_n = c_st_ctrl;
              default:   w_state_n = c_st_idle;
            endcase
          end
        end
      end
      default: begin
        w_state_n = c_st_idle;
        w_ph_n    = c_ph_setup;
        w_div_n   = '0;
      end
    endcase
  end

  // Pin values are derived from the next state so every pin leaves a flop.
  always_comb begin : p_out
    w_in_frame_n = (w_state_n == c_st_cmd) || (w_state_n == c_st_data) ||
                   (w_state_n == c_st_ctrl);
    w_tx_byte    = frame_byte(w_state_n, w_byte_n, r_seg, r_led);
    w_stb_n      = !w_in_frame_n;
    w_clk_n      = !(w_in_frame_n && (w_ph_n == c_ph_lo));
    w_dio_n      = (w_in_frame_n && (w_ph_n != c_ph_setup)) ? w_tx_byte[w_bit_n] : 1'b1;
    w_busy_n     = (w_state_n != c_st_idle);
    w_done_n     = (r_state == c_st_gap3) && (w_state_n == c_st_idle);
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign tm_stb = r_stb;
  assign tm_clk = r_clk;
  assign tm_dio = r_dio;

endmodule
`default_nettype wire

// File: tb/tb_tm1638_refresh_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tm1638_refresh_ctrl
// Brief    : Bench decoding TM1638 pin activity of three instances (D=2,1,7)
// Revision : 1.0
// ============================================================================
module tb_tm1638_refresh_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  start_v;
  logic [63:0] seg_data;
  logic [7:0]  led;
  logic [2:0]  busy_v, done_v, stb_v, clk_v, dio_v;

  tm1638_refresh_ctrl #(.CLK_DIV(2), .BRIGHTNESS(3'd7)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .seg_data(seg_data), .led(led),
    .busy(busy_v[0]), .done(done_v[0]), .tm_stb(stb_v[0]), .tm_clk(clk_v[0]), .tm_dio(dio_v[0]));
  tm1638_refresh_ctrl #(.CLK_DIV(1), .BRIGHTNESS(3'd0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .seg_data(seg_data), .led(led),
    .busy(busy_v[1]), .done(done_v[1]), .tm_stb(stb_v[1]), .tm_clk(clk_v[1]), .tm_dio(dio_v[1]));
  tm1638_refresh_ctrl #(.CLK_DIV(7), .BRIGHTNESS(3'd7)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .seg_data(seg_data), .led(led),
    .busy(busy_v[2]), .done(done_v[2]), .tm_stb(stb_v[2]), .tm_clk(clk_v[2]), .tm_dio(dio_v[2]));

  typedef struct {
    int          sel;
    logic [63:0] seg;
    logic [7:0]  led;
    logic [7:0]  ctrl;
    int          len;
    bit          mid_start;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] exp_q[$];
  int         fsz_q[$];
  int         n_tests, n_fail;
  int         sel, cyc, acc_cyc, last_len, done_cnt;
  int         mon_fr, mon_nbytes, mon_bits;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int dv(input int s);
    case (s)
      0:       return 2;
      1:       return 1;
      default: return 7;
    endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_seq(input logic [63:0] s, input logic [7:0] l, input logic [7:0] c);
    exp_q.push_back(8'h40);
    fsz_q.push_back(1);
    exp_q.push_back(8'hC0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(s[8*i +: 8]);
      exp_q.push_back({7'b0, l[i]});
    end
    fsz_q.push_back(17);
    exp_q.push_back(c);
    fsz_q.push_back(1);
  endtask

  // Decodes the selected instance's pins once per cycle, on the falling clock.
  task automatic monitor();
    logic       s, c, d, b, dn, pstb, pclk, pdio, pbusy;
    logic [7:0] acc, e;
    int         run, dd, fe;
    pstb = 1'b1; pclk = 1'b1; pdio = 1'b1; pbusy = 1'b0; run = 0; acc = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pstb = 1'b1; pclk = 1'b1; pdio = 1'b1; pbusy = 1'b0; run = 0;
        mon_fr = 0; mon_nbytes = 0; mon_bits = 0;
      end else begin
        s = stb_v[sel]; c = clk_v[sel]; d = dio_v[sel]; b = busy_v[sel]; dn = done_v[sel];
        dd = dv(sel);
        if (b && !pbusy) begin
          acc_cyc = cyc;
          mon_fr  = 0;
        end
        if (dn) begin
          last_len = cyc - acc_cyc;
          chk("frames_per_seq", mon_fr, 3);
          chk("busy_in_done", b, 0);
          done_cnt++;
        end
        if (s) chk("dio_idle", d, 1);
        if (s != pstb || c != pclk) begin
          if (pstb && !s) begin
            if (mon_fr > 0) chk("gap_len", run, 2*dd);
            mon_nbytes = 0;
            mon_bits   = 0;
          end else if (!pstb && s) begin
            chk("clk_at_stb_rise", c, 1);
            chk("hold_len", run, 2*dd);
            chk("whole_bytes", mon_bits, 0);
            chk("frame_q_nonempty", fsz_q.size() > 0, 1);
            fe = -1;
            if (fsz_q.size() > 0) fe = fsz_q.pop_front();
            chk("frame_bytes", mon_nbytes, fe);
            mon_fr++;
          end else if (!s && pclk && !c) begin
            chk("clk_hi_len", run, dd);
          end else if (!s && !pclk && c) begin
            chk("clk_lo_len", run, dd);
            chk("dio_at_rise", d, pdio);
            acc = {d, acc[7:1]};
            mon_bits++;
            if (mon_bits == 8) begin
              chk("byte_q_nonempty", exp_q.size() > 0, 1);
              if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("dio_byte", acc, e);
              end
              mon_bits = 0;
              mon_nbytes++;
            end
          end
          run = 1;
        end else begin
          run++;
          if (!s && c) chk("dio_stable_clk_hi", d, pdio);
        end
        pstb = s; pclk = c; pdio = d; pbusy = b;
      end
    end
  endtask

  task automatic wait_done(input int base, input int budget);
    int n;
    n = 0;
    while (done_cnt == base && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", done_cnt != base, 1);
  endtask

  task automatic chk_idle_pins(input int i);
    chk($sformatf("rst_stb%0d", i),  stb_v[i],  1);
    chk($sformatf("rst_clk%0d", i),  clk_v[i],  1);
    chk($sformatf("rst_dio%0d", i),  dio_v[i],  1);
    chk($sformatf("rst_busy%0d", i), busy_v[i], 0);
    chk($sformatf("rst_done%0d", i), done_v[i], 0);
  endtask

  task automatic run_vec(input vec_t v);
    int base;
    sel      = v.sel;
    seg_data = v.seg;
    led      = v.led;
    push_seq(v.seg, v.led, v.ctrl);
    base = done_cnt;
    start_v[v.sel] = 1'b1;
    @(posedge clk); #1;
    start_v  = '0;
    seg_data = ~v.seg;
    led      = ~v.led;
    if (v.mid_start) begin
      repeat (150) @(posedge clk);
      #1;
      chk("busy_mid", busy_v[v.sel], 1);
      start_v[v.sel] = 1'b1;
      @(posedge clk); #1;
      start_v = '0;
    end
    wait_done(base, 316*dv(v.sel) + 64);
    chk("seq_len", last_len, v.len);
    chk("byte_q_drained", exp_q.size(), 0);
    chk("busy_after", busy_v[v.sel], 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int base, n;
    n_tests = 0; n_fail = 0; sel = 0; cyc = 0; acc_cyc = 0; last_len = 0; done_cnt = 0;
    mon_fr = 0; mon_nbytes = 0; mon_bits = 0;
    rst = 1'b0; start_v = '0; seg_data = '0; led = '0;

    vecs[0] = '{0, {8{8'h3F}},            8'hA5, 8'h8F, 632,  1'b0};
    vecs[1] = '{0, 64'h0123_4567_89AB_CDEF, 8'h3C, 8'h8F, 632,  1'b1};
    vecs[2] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'h88, 316,  1'b0};
    vecs[3] = '{2, 64'h8001_4002_2004_1008, 8'h81, 8'h8F, 2212, 1'b0};
    vecs[4] = '{1, 64'h0,                   8'h00, 8'h88, 316,  1'b0};
    vecs[5] = '{2, 64'h7E5A_A5C3_3C00_FF69, 8'h5A, 8'h8F, 2212, 1'b0};

    fork
      monitor();
    join_none

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk_idle_pins(i);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Start held high: latched data, then back-to-back restart in the done cycle.
    sel      = 0;
    seg_data = 64'h1122_3344_5566_7788;
    led      = 8'h5A;
    push_seq(64'h1122_3344_5566_7788, 8'h5A, 8'h8F);
    base = done_cnt;
    start_v[0] = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("hold_busy", busy_v[0], 1);
    seg_data = ~64'h1122_3344_5566_7788;
    led      = ~8'h5A;
    push_seq(~64'h1122_3344_5566_7788, ~8'h5A, 8'h8F);
    wait_done(base, 700);
    chk("b2b_len1", last_len, 632);
    chk("b2b_busy", busy_v[0], 1);
    chk("b2b_stb", stb_v[0], 0);
    start_v = '0;
    base = done_cnt;
    wait_done(base, 700);
    chk("b2b_len2", last_len, 632);
    chk("b2b_q_drained", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;

    // Reset during bit 3 of data byte 5 aborts; the next refresh is complete.
    seg_data = 64'hDEAD_BEEF_CAFE_F00D;
    led      = 8'hC3;
    push_seq(64'hDEAD_BEEF_CAFE_F00D, 8'hC3, 8'h8F);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    n = 0;
    while (!(mon_fr == 1 && mon_nbytes == 5 && mon_bits == 3 && clk_v[0] == 1'b0) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_byte5_bit3", n < 2000, 1);
    #2 rst = 1'b1;
    #1;
    chk_idle_pins(0);
    exp_q.delete();
    fsz_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
